// File: rtl/vga_scan_driver.sv
// VGA raster generator: pixel-rate strobe, h/v counters, syncs and blanking,
// with the sprite colour registered onto the DAC pins one pixel after pixelx/pixely.
module vga_scan_driver #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33,
  parameter int          CLK_DIV   = 2,
  parameter logic [23:0] BG_RGB    = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] sprite_rgb,
  input  logic        sprite_visible,
  output logic [9:0]  pixelx,
  output logic [9:0]  pixely,
  output logic        pix_en,
  output logic        vga_clk,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [23:0] vga_rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic             vga_clk_q, vga_clk_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             blank_n_q, blank_n_d;
  logic [23:0]      vga_rgb_q, vga_rgb_d;
  logic             active, hs_win, vs_win, pix_en_w;

  always_comb begin
    pix_en_w  = (div_q == DIV_LAST);
    div_d     = pix_en_w ? '0 : div_q + 1'b1;
    vga_clk_d = (div_q >= DIV_HALF);

    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en_w) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end

    active = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    hs_win = (hcount_q >= HS_START) && (hcount_q <= HS_END);
    vs_win = (vcount_q >= VS_START) && (vcount_q <= VS_END);

    // Output stage samples the pixel currently presented to the sprites.
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    blank_n_d = blank_n_q;
    vga_rgb_d = vga_rgb_q;
    if (pix_en_w) begin
      hsync_d   = !hs_win;
      vsync_d   = !vs_win;
      blank_n_d = active;
      vga_rgb_d = active ? (sprite_visible ? sprite_rgb : BG_RGB) : 24'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      vga_clk_q <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_n_q <= 1'b0;
      vga_rgb_q <= 24'h0;
    end else begin
      div_q     <= div_d;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      vga_clk_q <= vga_clk_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_n_q <= blank_n_d;
      vga_rgb_q <= vga_rgb_d;
    end
  end

  assign pixelx      = hcount_q;
  assign pixely      = vcount_q;
  assign pix_en      = pix_en_w;
  assign vga_clk     = vga_clk_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign vga_rgb     = vga_rgb_q;
  assign frame_start = pix_en_w && (hcount_q == 10'd0) && (vcount_q == 10'd0);

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench for vga_scan_driver: full 800-pixel lines with a shortened
// 12-line frame (vsync on lines 8..9) so a whole frame fits in a short run.
module tb_vga_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] sprite_rgb;
  logic        sprite_visible;
  logic [9:0]  pixelx, pixely;
  logic        pix_en, vga_clk, hsync, vsync, blank_n, frame_start;
  logic [23:0] vga_rgb;

  logic mode_solid;
  int   checks = 0;
  int   failures = 0;
  int   wait_n;

  vga_scan_driver #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(2), .BG_RGB(24'h0000A5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sprite_rgb(sprite_rgb), .sprite_visible(sprite_visible),
    .pixelx(pixelx), .pixely(pixely), .pix_en(pix_en), .vga_clk(vga_clk),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .vga_rgb(vga_rgb),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Sprite renderer stand-in: either solid white everywhere, or one red pixel at (100,3).
  always_comb begin
    if (mode_solid) begin
      sprite_visible = 1'b1;
      sprite_rgb     = 24'hFFFFFF;
    end else begin
      sprite_visible = (pixelx == 10'd100) && (pixely == 10'd3);
      sprite_rgb     = sprite_visible ? 24'hFF0000 : 24'h123456;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge on which pix_en is high; wait_n = negedges taken.
  task automatic next_pix();
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!pix_en && wait_n < 16);
    if (!pix_en) check("pix_en_timeout", 32'd0, 32'd1);
  endtask

  task automatic walk_to(input logic [9:0] x, input logic [9:0] y);
    int steps = 0;
    do begin
      next_pix();
      steps++;
    end while (!(pixelx == x && pixely == y) && steps < 20000);
    if (!(pixelx == x && pixely == y)) check("walk_timeout", {12'd0, pixely, pixelx}, {12'd0, y, x});
  endtask

  initial begin
    int hs_low, vs_low, blank_cnt, white_cnt, bad_rgb, fs_early, clk_sum, vclk_hi;
    logic [19:0] first_hs, first_vs, pos_799, pos_800;
    logic seen_hs, seen_vs;

    rst_n = 1'b0;
    mode_solid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hsync", {31'd0, hsync}, 32'd1);
    check("rst_vsync", {31'd0, vsync}, 32'd1);
    check("rst_blank_n", {31'd0, blank_n}, 32'd0);
    check("rst_rgb", {8'd0, vga_rgb}, 32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_pos", {12'd0, pixely, pixelx}, 32'd0);

    rst_n = 1'b1;
    check("rel_pix_en_low", {31'd0, pix_en}, 32'd0);
    next_pix();
    check("rel_first_pix_clks", wait_n, 32'd1);
    check("rel_frame_start", {31'd0, frame_start}, 32'd1);
    check("rel_pos", {12'd0, pixely, pixelx}, 32'd0);
    check("rel_syncs_blank", {29'd0, hsync, vsync, blank_n}, 32'b110);

    // One full frame; at step k the output register shows pixel k-1.
    hs_low = 0; vs_low = 0; blank_cnt = 0; white_cnt = 0; bad_rgb = 0;
    fs_early = 0; clk_sum = 0; vclk_hi = 0;
    seen_hs = 1'b0; seen_vs = 1'b0;
    first_hs = '0; first_vs = '0; pos_799 = '0; pos_800 = '0;
    for (int k = 1; k <= 9600; k++) begin
      next_pix();
      clk_sum += wait_n;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (blank_n) blank_cnt++;
      if (blank_n && vga_rgb == 24'hFFFFFF) white_cnt++;
      if (!blank_n && vga_rgb != 24'h0) bad_rgb++;
      if (vga_clk) vclk_hi++;
      if (k < 9600 && frame_start) fs_early++;
      if (!hsync && !seen_hs) begin seen_hs = 1'b1; first_hs = {pixely, pixelx}; end
      if (!vsync && !seen_vs) begin seen_vs = 1'b1; first_vs = {pixely, pixelx}; end
      if (k == 799) pos_799 = {pixely, pixelx};
      if (k == 800) pos_800 = {pixely, pixelx};
    end
    check("frame_start_next", {31'd0, frame_start}, 32'd1);
    check("frame_wrap_pos", {12'd0, pixely, pixelx}, 32'd0);
    check("frame_clks", clk_sum, 32'd19200);
    check("frame_start_extra", fs_early, 32'd0);
    check("hsync_low_total", hs_low, 32'd1152);
    check("hsync_first_low", {12'd0, first_hs}, {12'd0, 10'd0, 10'd657});
    check("vsync_low_total", vs_low, 32'd1600);
    check("vsync_first_low", {12'd0, first_vs}, {12'd0, 10'd8, 10'd1});
    check("line_pos_799", {12'd0, pos_799}, {12'd0, 10'd0, 10'd799});
    check("line_wrap_800", {12'd0, pos_800}, {12'd0, 10'd1, 10'd0});
    check("blank_n_count", blank_cnt, 32'd3840);
    check("active_white_count", white_cnt, 32'd3840);
    check("rgb_in_blank", bad_rgb, 32'd0);
    check("vga_clk_at_pix_en", vclk_hi, 32'd0);

    // Single red sprite pixel at (100,3) with background elsewhere.
    mode_solid = 1'b0;
    walk_to(10'd100, 10'd3);
    check("sprite_left_bg", {8'd0, vga_rgb}, 32'h0000A5);
    next_pix();
    check("sprite_hit", {8'd0, vga_rgb}, 32'hFF0000);
    check("sprite_hit_blank_n", {31'd0, blank_n}, 32'd1);
    next_pix();
    check("sprite_right_bg", {8'd0, vga_rgb}, 32'h0000A5);

    // Mid-frame asynchronous reset.
    mode_solid = 1'b1;
    walk_to(10'd300, 10'd4);
    check("pre_rst_rgb", {8'd0, vga_rgb}, 32'hFFFFFF);
    @(negedge clk);
    check("vga_clk_high_phase", {30'd0, vga_clk, pix_en}, 32'b10);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pos", {12'd0, pixely, pixelx}, 32'd0);
    check("async_rst_outs", {28'd0, hsync, vsync, blank_n, vga_clk}, 32'b1100);
    check("async_rst_rgb", {8'd0, vga_rgb}, 32'd0);
    check("async_rst_strobes", {30'd0, pix_en, frame_start}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_pix();
    check("restart_clks", wait_n, 32'd1);
    check("restart_frame_start", {31'd0, frame_start}, 32'd1);
    check("restart_pos", {12'd0, pixely, pixelx}, 32'd0);
    next_pix();
    check("restart_step_clks", wait_n, 32'd2);
    check("restart_pixelx1", {22'd0, pixelx}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
